rvlife_boot_ctrl: RTL and testbench
===================================

// Module: rvlife_boot_ctrl
// PURPOSE
//  Sequences the single-cycle core for a test run.
//  - Streams a byte-wide program image into the instruction ROM write port.
//  - Holds the core in reset, then releases it and counts run cycles.
//  - Watches the end-of-test registers: x26 = done, x27 = pass, x3 = test number.
//  - Reports pass / fail / timeout, so the same program images run unattended on silicon or FPGA.
// PARAMETERS
//  ADDR_W      10    ROM word-address width; capacity 2**ADDR_W words
//  RESET_HOLD  2     cycles core_rstn is held low after a load, 1..15
//  TIMEOUT     5000  max run cycles before a timeout is declared, >=2
// PORTS
//  clk        in   1       system clock
//  rst        in   1       synchronous reset, active-high
//  start      in   1       1-cycle pulse: begin load; honoured in IDLE or DONE only
//  ld_valid   in   1       loader byte valid
//  ld_data    in   8       loader byte, little-endian within each 32-bit word
//  ld_last    in   1       marks the final byte of the image
//  ld_ready   out  1       loader byte accepted when ld_valid & ld_ready
//  rom_we     out  1       ROM write strobe, 1 cycle per word
//  rom_addr   out  ADDR_W  ROM word address
//  rom_wdata  out  32      ROM write data
//  core_rstn  out  1       active-low reset to the core
//  x26_val    in   32      core register x26 (done flag)
//  x27_val    in   32      core register x27 (pass flag)
//  x3_val     in   32      core register x3 (test number)
//  busy       out  1       state is not IDLE and not DONE
//  done       out  1       run finished, sticky until start or rst
//  pass       out  1       x27==1 at check, sticky
//  fail       out  1       x27!=1 at check, or load overflow, sticky
//  timeout    out  1       TIMEOUT reached, sticky
//  fail_num   out  32      x3 latched at fail; 0 otherwise
//  cycle_cnt  out  32      core run cycles counted in RUN
// BEHAVIOUR
//  Reset values: state IDLE; core_rstn=0; all other outputs 0; byte index 0.
//    rst in any state aborts the run, returns to IDLE and applies these values on the next edge.
//  FSM states: IDLE, LOAD, HOLD, RUN, CHECK, DONE.
//  IDLE/DONE + start -> LOAD.
//    Clears done, pass, fail, timeout, fail_num, cycle_cnt, rom_addr and the byte index.
//    core_rstn=0.
//  LOAD:
//    - ld_ready=1.
//    - Each accepted byte goes into lane [8*idx +: 8]; idx increments mod 4.
//    - On the 4th byte, or on ld_last: rom_we=1 and rom_wdata=assembled word in the next cycle.
//      Unfilled lanes of a partial word are 0. rom_addr is incremented after each write.
//    - ld_last -> HOLD, with ld_ready=0 from the next cycle.
//    - A byte accepted after word 2**ADDR_W-1 has been written is an overflow.
//      The byte is not written; go to DONE with fail=1, fail_num=32'hFFFF_FFFF.
//    - start is ignored in LOAD.
//  HOLD: core_rstn=0 for RESET_HOLD cycles, then -> RUN.
//  RUN:
//    - core_rstn=1; cycle_cnt increments each cycle.
//    - x26_val==1 -> CHECK.
//    - Otherwise, cycle_cnt==TIMEOUT-1 -> DONE with timeout=1.
//    - If both occur in the same cycle, the done flag wins.
//  CHECK: one cycle after x26 is seen, sample x27_val.
//    ==1: pass=1. Else: fail=1 and fail_num=x3_val.
//    -> DONE.
//  DONE: core_rstn=0 (core frozen), done=1; flags hold until start.
//  Outputs are registered; no combinational path from inputs to outputs.
// TESTING
//  Load 8 bytes 13 05 00 00 93 05 10 00 (ld_last on byte 8) -> two rom_we pulses:
//    addr0=0x00000513, addr1=0x00100593; core_rstn rises 2 cycles after HOLD is entered.
//  Load 5 bytes, ld_last on the 5th (0xAB) -> word1=0x000000AB; exactly 2 writes.
//  Drive x26=1 at run cycle 40 and x27=1 the next cycle -> done=1, pass=1, fail=0, cycle_cnt=41.
//  Drive x26=1, x27=0, x3=7 -> fail=1, fail_num=7, core_rstn=0.
//  Never assert x26 -> timeout=1 after exactly 5000 RUN cycles.
//    Separately, x26=1 in cycle 4999 -> CHECK, not timeout.
//  Assert rst mid-LOAD and mid-RUN -> IDLE, all outputs 0; a new start reloads from addr 0.

Source files
------------

// File: rtl/rvlife_boot_ctrl.sv
// rvlife_boot_ctrl: loads a byte-stream program into ROM, runs the core, and reports pass/fail/timeout.
module rvlife_boot_ctrl #(
    parameter int ADDR_W     = 10,
    parameter int RESET_HOLD = 2,
    parameter int TIMEOUT    = 5000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              ld_valid,
    input  logic [7:0]        ld_data,
    input  logic              ld_last,
    output logic              ld_ready,
    output logic              rom_we,
    output logic [ADDR_W-1:0] rom_addr,
    output logic [31:0]       rom_wdata,
    output logic              core_rstn,
    input  logic [31:0]       x26_val,
    input  logic [31:0]       x27_val,
    input  logic [31:0]       x3_val,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic              fail,
    output logic              timeout,
    output logic [31:0]       fail_num,
    output logic [31:0]       cycle_cnt
);
    typedef enum logic [2:0] {IDLE, LOAD, HOLD, RUN, CHECK, DONE} state_t;
    state_t      state;
    logic [1:0]  idx;
    logic [31:0] word;
    logic [3:0]  hold_cnt;
    logic        full;
    logic [31:0] merged;
    logic        accept;
    logic        wrote_last;
    logic        flush;
    assign merged     = word | (32'(ld_data) << {idx, 3'b000});
    assign accept     = ld_valid & ld_ready;
    assign wrote_last = rom_we & (rom_addr == '1);
    assign flush      = (idx == 2'd3) | ld_last;
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            idx       <= '0;
            word      <= '0;
            hold_cnt  <= '0;
            full      <= 1'b0;
            ld_ready  <= 1'b0;
            rom_we    <= 1'b0;
            rom_addr  <= '0;
            rom_wdata <= '0;
            core_rstn <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            pass      <= 1'b0;
            fail      <= 1'b0;
            timeout   <= 1'b0;
            fail_num  <= '0;
            cycle_cnt <= '0;
        end else begin
            rom_we <= 1'b0;
            if (rom_we) rom_addr <= rom_addr + ADDR_W'(1);
            // the top word is written once; any byte after it is an overflow
            if (wrote_last) full <= 1'b1;
            case (state)
                IDLE, DONE: if (start) begin
                    state     <= LOAD;
                    ld_ready  <= 1'b1;
                    busy      <= 1'b1;
                    done      <= 1'b0;
                    pass      <= 1'b0;
                    fail      <= 1'b0;
                    timeout   <= 1'b0;
                    fail_num  <= '0;
                    cycle_cnt <= '0;
                    rom_addr  <= '0;
                    idx       <= '0;
                    word      <= '0;
                    full      <= 1'b0;
                    core_rstn <= 1'b0;
                end
                LOAD: if (accept) begin
                    if (full | wrote_last) begin
                        state    <= DONE;
                        ld_ready <= 1'b0;
                        busy     <= 1'b0;
                        done     <= 1'b1;
                        fail     <= 1'b1;
                        fail_num <= '1;
                    end else begin
                        idx  <= idx + 2'd1;
                        word <= flush ? '0 : merged;
                        if (flush) begin
                            rom_we    <= 1'b1;
                            rom_wdata <= merged;
                        end
                        if (ld_last) begin
                            state    <= HOLD;
                            ld_ready <= 1'b0;
                            hold_cnt <= '0;
                        end
                    end
                end
                HOLD: if (hold_cnt == 4'(RESET_HOLD - 1)) begin
                    state     <= RUN;
                    core_rstn <= 1'b1;
                end else hold_cnt <= hold_cnt + 4'd1;
                RUN: begin
                    cycle_cnt <= cycle_cnt + 32'd1;
                    if (x26_val == 32'd1) state <= CHECK;
                    else if (cycle_cnt == 32'(TIMEOUT - 1)) begin
                        state     <= DONE;
                        timeout   <= 1'b1;
                        done      <= 1'b1;
                        busy      <= 1'b0;
                        core_rstn <= 1'b0;
                    end
                end
                CHECK: begin
                    state     <= DONE;
                    done      <= 1'b1;
                    busy      <= 1'b0;
                    core_rstn <= 1'b0;
                    if (x27_val == 32'd1) pass <= 1'b1;
                    else begin
                        fail     <= 1'b1;
                        fail_num <= x3_val;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_rvlife_boot_ctrl.sv
// tb_rvlife_boot_ctrl: random loads and runs of rvlife_boot_ctrl against a behavioural outcome model.
module tb_rvlife_boot_ctrl;
    localparam int AW = 10;
    localparam int TO = 5000;
    typedef logic [7:0] bytes_t[$];
    logic clk = 1'b0, rst, start, ld_valid, ld_last, ld_ready, rom_we, core_rstn;
    logic busy, done, pass, fail, timeout;
    logic [7:0] ld_data;
    logic [AW-1:0] rom_addr;
    logic [31:0] rom_wdata, x26_val, x27_val, x3_val, fail_num, cycle_cnt;
    int checks = 0, errors = 0;
    logic [AW-1:0] wa[$];
    logic [31:0] wd[$];
    bytes_t b;

    rvlife_boot_ctrl #(.ADDR_W(AW), .RESET_HOLD(2), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .start(start), .ld_valid(ld_valid), .ld_data(ld_data),
        .ld_last(ld_last), .ld_ready(ld_ready), .rom_we(rom_we), .rom_addr(rom_addr),
        .rom_wdata(rom_wdata), .core_rstn(core_rstn), .x26_val(x26_val), .x27_val(x27_val),
        .x3_val(x3_val), .busy(busy), .done(done), .pass(pass), .fail(fail),
        .timeout(timeout), .fail_num(fail_num), .cycle_cnt(cycle_cnt)
    );

    always #5 clk = ~clk;
    always @(negedge clk) if (rom_we) begin
        wa.push_back(rom_addr);
        wd.push_back(rom_wdata);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic check_idle(input string tag);
        chk({tag, "_flags"}, 32'({ld_ready, rom_we, core_rstn, busy, done, pass, fail, timeout}), 32'd0);
        chk({tag, "_addr"}, 32'(rom_addr), 32'd0);
        chk({tag, "_wdata"}, rom_wdata, 32'd0);
        chk({tag, "_fail_num"}, fail_num, 32'd0);
        chk({tag, "_cycle_cnt"}, cycle_cnt, 32'd0);
    endtask

    task automatic pulse_rst();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Feeds bytes with random gaps and stray start pulses; returns at the negedge after the final accept.
    task automatic load(input bytes_t img, input bit last);
        int i = 0, guard = 0;
        bit v;
        wa.delete();
        wd.delete();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("ld_ready_on", 32'(ld_ready), 32'd1);
        while (i < img.size() && guard < 20000) begin
            v = ($urandom_range(3) != 0);
            start = ($urandom_range(7) == 0);
            ld_valid = v;
            ld_data = v ? img[i] : 8'($urandom);
            ld_last = v && last && (i == img.size() - 1);
            if (v && ld_ready) i++;
            @(negedge clk);
            guard++;
        end
        ld_valid = 1'b0;
        ld_last = 1'b0;
        start = 1'b0;
        chk("load_complete", 32'(i), 32'(img.size()));
    endtask

    task automatic hold_check();
        chk("ld_ready_off", 32'(ld_ready), 32'd0);
        chk("hold_rstn0", 32'(core_rstn), 32'd0);
        @(negedge clk);
        chk("hold_rstn1", 32'(core_rstn), 32'd0);
        @(negedge clk);
        chk("hold_rstn_rise", 32'(core_rstn), 32'd1);
    endtask

    task automatic check_writes(input bytes_t img, input int nb);
        int nw;
        logic [31:0] e;
        nw = (nb + 3) / 4;
        chk("wr_count", 32'(wa.size()), 32'(nw));
        for (int w = 0; w < nw && w < wa.size(); w++) begin
            e = '0;
            for (int j = 0; j < 4 && 4 * w + j < nb; j++) e[8*j+:8] = img[4*w+j];
            chk("wr_addr", 32'(wa[w]), 32'(w));
            chk("wr_data", wd[w], e);
        end
    endtask

    // Starts at run cycle 0; x26 goes to 1 in run cycle k (k >= TO means never).
    task automatic run(input int k, input logic [31:0] x27v, input logic [31:0] x3v);
        int n = 0;
        bit to, exp_pass, exp_fail;
        to = (k >= TO);
        exp_pass = !to && (x27v == 32'd1);
        exp_fail = !to && (x27v != 32'd1);
        chk("busy_run", 32'(busy), 32'd1);
        x27_val = (x27v == 32'd1) ? 32'd0 : 32'd1;
        x3_val = ~x3v;
        while (!done && n < TO + 10) begin
            x26_val = (n == k) ? 32'd1 : ($urandom_range(1) ? 32'd0 : 32'd2);
            if (n == k + 1) begin
                x27_val = x27v;
                x3_val = x3v;
            end
            @(negedge clk);
            n++;
        end
        x26_val = '0;
        chk("run_len", 32'(n), to ? 32'(TO) : 32'(k + 2));
        chk("done", 32'(done), 32'd1);
        chk("pass", 32'(pass), 32'(exp_pass));
        chk("fail", 32'(fail), 32'(exp_fail));
        chk("timeout", 32'(timeout), 32'(to));
        chk("fail_num", fail_num, exp_fail ? x3v : 32'd0);
        chk("cycle_cnt", cycle_cnt, to ? 32'(TO) : 32'(k + 1));
        chk("done_rstn_busy", 32'({core_rstn, busy}), 32'd0);
    endtask

    task automatic full_test(input int nbytes, input int k, input logic [31:0] x27v, input logic [31:0] x3v);
        b.delete();
        repeat (nbytes) b.push_back(8'($urandom));
        load(b, 1'b1);
        hold_check();
        check_writes(b, nbytes);
        run(k, x27v, x3v);
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        ld_valid = 1'b0;
        ld_last = 1'b0;
        ld_data = '0;
        x26_val = '0;
        x27_val = '0;
        x3_val = '0;
        repeat (3) @(negedge clk);
        check_idle("reset");
        rst = 1'b0;
        b = '{8'h13, 8'h05, 8'h00, 8'h00, 8'h93, 8'h05, 8'h10, 8'h00};
        load(b, 1'b1);
        hold_check();
        check_writes(b, 8);
        chk("w0_fixed", wd[0], 32'h0000_0513);
        chk("w1_fixed", wd[1], 32'h0010_0593);
        run(40, 32'd1, 32'd0);
        b = '{8'h11, 8'h22, 8'h33, 8'h44, 8'hAB};
        load(b, 1'b1);
        hold_check();
        check_writes(b, 5);
        chk("w1_partial", wd[1], 32'h0000_00AB);
        run(12, 32'd0, 32'd7);
        for (int t = 0; t < 8; t++)
            full_test($urandom_range(1, 24), $urandom_range(0, 300),
                      ($urandom_range(2) == 0) ? 32'd1 : $urandom, $urandom);
        full_test(3, TO - 1, 32'd1, 32'd5);
        full_test(6, TO, 32'd1, 32'd5);
        b.delete();
        repeat (6) b.push_back(8'($urandom));
        load(b, 1'b0);
        pulse_rst();
        check_idle("rst_load");
        full_test(9, 20, 32'd3, 32'd99);
        b.delete();
        repeat (7) b.push_back(8'($urandom));
        load(b, 1'b1);
        hold_check();
        repeat (10) @(negedge clk);
        pulse_rst();
        check_idle("rst_run");
        full_test(7, 5, 32'd1, 32'd0);
        b.delete();
        repeat ((1 << AW) * 4 + 1) b.push_back(8'($urandom));
        load(b, 1'b0);
        chk("ovf_flags", 32'({done, fail, pass, busy, ld_ready, timeout}), 32'b110000);
        chk("ovf_fail_num", fail_num, 32'hFFFF_FFFF);
        @(negedge clk);
        check_writes(b, (1 << AW) * 4);
        full_test(4, 2, 32'd1, 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
